// File: rtl/adc_udp_channel_arbiter_if.sv
// AXI-Stream bundle between the ADC channel sources and the merged UDP framer stream.
// The arbiter connects through the slave modport; the environment (sources plus sink) uses master.
interface adc_udp_channel_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 128,
  parameter int CH_W       = 2
);
  logic [NUM_CH*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_CH-1:0]            s_axis_tvalid;
  logic [NUM_CH-1:0]            s_axis_tlast;
  logic [NUM_CH-1:0]            s_axis_tready;

  logic [DATA_WIDTH-1:0]        m_axis_tdata;
  logic                         m_axis_tvalid;
  logic                         m_axis_tlast;
  logic                         m_axis_tready;
  logic [CH_W-1:0]              m_axis_tuser;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/adc_udp_channel_arbiter.sv
// Packet-atomic round-robin merge of NUM_CH ADC AXI-Stream channels onto one stream.
//
// state | meaning
// IDLE  | no packet owner; arbitrate among enabled, valid channels (takes one cycle)
// XFER  | granted channel is wired through to the merged stream until its tlast handshake
//
// The data path is purely combinational (no buffering); only the grant bookkeeping and
// the per-channel packet counters are registered.
module adc_udp_channel_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 128,
  parameter int CH_W       = 2
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  adc_udp_channel_arbiter_if.slave axis,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic                    cnt_clear,
  output logic [NUM_CH*32-1:0]    pkt_cnt,
  output logic                    busy
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         grant_q, grant_d;
  logic [CH_W-1:0]         last_grant_q, last_grant_d;
  logic                    busy_q, busy_d;
  logic [NUM_CH-1:0][31:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0]   ch_data [NUM_CH];
  logic [NUM_CH-1:0]       req;
  logic [CH_W-1:0]         rr_pick;
  logic                    active;
  logic                    pkt_done;

  // Unpack the flattened per-channel data bus.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch_data[g] = axis.s_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req = axis.s_axis_tvalid & ch_enable;

  // Round-robin search: first requesting channel after last_grant, wrapping at NUM_CH.
  always_comb begin
    int  idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    rr_pick = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_grant_q) + i) % NUM_CH;
      if (!found && req[idx[CH_W-1:0]]) begin
        found   = 1'b1;
        rr_pick = idx[CH_W-1:0];
      end
    end
  end

  // Merged-stream mux; gated by reset so nothing handshakes while ARESET is high.
  always_comb begin
    active             = (state_q == XFER) && !ARESET;
    axis.m_axis_tdata  = '0;
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tlast  = 1'b0;
    axis.m_axis_tuser  = grant_q;
    axis.s_axis_tready = '0;
    if (active) begin
      axis.m_axis_tdata           = ch_data[grant_q];
      axis.m_axis_tvalid          = axis.s_axis_tvalid[grant_q];
      axis.m_axis_tlast           = axis.s_axis_tlast[grant_q];
      axis.s_axis_tready[grant_q] = axis.m_axis_tready;
    end
    pkt_done = active && axis.s_axis_tvalid[grant_q] && axis.s_axis_tlast[grant_q]
               && axis.m_axis_tready;
  end

  // Next-state logic for the FSM, grant bookkeeping and packet counters.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = rr_pick;
          state_d = XFER;
        end
      end
      XFER: begin
        if (pkt_done) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    for (int k = 0; k < NUM_CH; k++) begin
      if (pkt_done && (grant_q == CH_W'(k))) begin
        cnt_d[k] = cnt_q[k] + 32'd1;
      end
      // A clear arriving with an increment wins.
      if (cnt_clear) begin
        cnt_d[k] = '0;
      end
    end
    busy_d = (state_d == XFER);
  end

  // State register; last_grant resets to NUM_CH-1 so channel 0 wins the first arbitration.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      busy_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end

  assign pkt_cnt = cnt_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_adc_udp_channel_arbiter.sv
// Self-checking bench for adc_udp_channel_arbiter: directed scenarios plus a randomized
// run compared against a packet-level behavioural model.
module tb_adc_udp_channel_arbiter;
  localparam int NUM_CH = 4;
  localparam int DW     = 128;
  localparam int CH_W   = 2;

  logic                 ACLK = 1'b0;
  logic                 ARESET;
  logic [NUM_CH-1:0]    ch_enable;
  logic                 cnt_clear;
  logic [NUM_CH*32-1:0] pkt_cnt;
  logic                 busy;
  logic [31:0]          cnt_view [NUM_CH];

  adc_udp_channel_arbiter_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CH_W(CH_W)) axis_if ();

  adc_udp_channel_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CH_W(CH_W)) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .axis      (axis_if.slave),
    .ch_enable (ch_enable),
    .cnt_clear (cnt_clear),
    .pkt_cnt   (pkt_cnt),
    .busy      (busy)
  );

  always #5 ACLK = ~ACLK;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign cnt_view[g] = pkt_cnt[g*32 +: 32];
  end

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: who owns the output stream, who was served last, packet counts.
  bit              m_busy;
  logic [CH_W-1:0] m_owner;
  logic [CH_W-1:0] m_last;
  logic [31:0]     m_cnt [NUM_CH];

  logic              e_valid, e_last;
  logic [DW-1:0]     e_data;
  logic [NUM_CH-1:0] e_ready;
  logic [CH_W-1:0]   e_user;

  task automatic set_data(input int k, input logic [DW-1:0] v);
    axis_if.s_axis_tdata[k*DW +: DW] = v;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_eval();
    e_valid = 1'b0;
    e_last  = 1'b0;
    e_ready = '0;
    e_data  = '0;
    e_user  = '0;
    if (!ARESET && m_busy) begin
      e_valid          = axis_if.s_axis_tvalid[m_owner];
      e_last           = axis_if.s_axis_tlast[m_owner];
      e_data           = axis_if.s_axis_tdata[int'(m_owner)*DW +: DW];
      e_user           = m_owner;
      e_ready[m_owner] = axis_if.m_axis_tready;
    end
  endtask

  task automatic model_advance();
    logic [NUM_CH-1:0] req;
    logic [CH_W-1:0]   c;
    bit                found;
    if (ARESET) begin
      m_busy  = 0;
      m_owner = '0;
      m_last  = CH_W'(NUM_CH - 1);
      for (int k = 0; k < NUM_CH; k++) m_cnt[k] = '0;
    end else begin
      if (!m_busy) begin
        req   = axis_if.s_axis_tvalid & ch_enable;
        found = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
          c = CH_W'((int'(m_last) + i) % NUM_CH);
          if (!found && req[c]) begin
            found   = 1;
            m_owner = c;
          end
        end
        if (found) m_busy = 1;
      end else if (axis_if.s_axis_tvalid[m_owner] && axis_if.s_axis_tlast[m_owner]
                   && axis_if.m_axis_tready) begin
        m_cnt[m_owner] = m_cnt[m_owner] + 32'd1;
        m_last         = m_owner;
        m_busy         = 0;
      end
      if (cnt_clear) begin
        for (int k = 0; k < NUM_CH; k++) m_cnt[k] = '0;
      end
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic cycle();
    @(posedge ACLK);
    model_advance();
    @(negedge ACLK);
  endtask

  task automatic idle_inputs();
    axis_if.s_axis_tvalid = '0;
    axis_if.s_axis_tlast  = '0;
    axis_if.s_axis_tdata  = '0;
    axis_if.m_axis_tready = 1'b1;
    cnt_clear             = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARESET = 1'b1;
    cycle();
    cycle();
    ARESET = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ch_enable             = '1;
    axis_if.s_axis_tvalid = '1;
    ARESET                = 1'b1;
    cycle();
    settle();
    n_vec++;
    if (axis_if.m_axis_tvalid !== 1'b0)
      begin n_err++; $display("FAIL rst_tvalid: got %b want 0", axis_if.m_axis_tvalid); end
    n_vec++;
    if (axis_if.s_axis_tready !== '0)
      begin n_err++; $display("FAIL rst_tready: got %b want 0000", axis_if.s_axis_tready); end
    cycle();
    ARESET                = 1'b0;
    axis_if.s_axis_tvalid = '0;
    settle();
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++;
    if (axis_if.s_axis_tready !== '0 || axis_if.m_axis_tvalid !== 1'b0)
      begin n_err++; $display("FAIL rst_after: tready %b tvalid %b want 0", axis_if.s_axis_tready, axis_if.m_axis_tvalid); end
    for (int k = 0; k < NUM_CH; k++) begin
      n_vec++;
      if (cnt_view[k] !== 32'd0)
        begin n_err++; $display("FAIL rst_cnt%0d: got %h want 0", k, cnt_view[k]); end
    end
    cycle();
  endtask

  task automatic test_fairness();
    logic [NUM_CH-1:0] bc;
    int                beats;
    int                hs_ch;
    bit                hs;
    do_reset();
    ch_enable             = 4'hF;
    axis_if.s_axis_tvalid = 4'hF;
    bc                    = '0;
    beats                 = 0;
    for (int c = 0; c < 24; c++) begin
      axis_if.s_axis_tlast = bc;
      for (int k = 0; k < NUM_CH; k++) set_data(k, DW'(k * 16 + int'(bc[k])));
      settle();
      n_vec++;
      if (axis_if.m_axis_tvalid !== ((c % 3) != 0))
        begin n_err++; $display("FAIL fair_slot c=%0d: tvalid %b want %b", c, axis_if.m_axis_tvalid, (c % 3) != 0); end
      hs = 0;
      hs_ch = 0;
      if (axis_if.m_axis_tvalid === 1'b1 && axis_if.m_axis_tready === 1'b1) begin
        n_vec++;
        if (axis_if.m_axis_tuser !== CH_W'((beats / 2) % NUM_CH))
          begin n_err++; $display("FAIL fair_tuser beat %0d: got %0d want %0d", beats, axis_if.m_axis_tuser, (beats / 2) % NUM_CH); end
        hs    = 1;
        hs_ch = int'(axis_if.m_axis_tuser);
        beats++;
      end
      cycle();
      if (hs) bc[hs_ch] = ~bc[hs_ch];
    end
    n_vec++;
    if (beats != 16) begin n_err++; $display("FAIL fair_beats: got %0d want 16", beats); end
    for (int k = 0; k < NUM_CH; k++) begin
      n_vec++;
      if (cnt_view[k] !== 32'd2)
        begin n_err++; $display("FAIL fair_cnt%0d: got %0d want 2", k, cnt_view[k]); end
    end
  endtask

  task automatic test_masking();
    int ch2_beats;
    do_reset();
    ch_enable             = 4'b0100;
    axis_if.s_axis_tvalid = 4'hF;
    ch2_beats             = 0;
    for (int c = 0; c < 30; c++) begin
      axis_if.s_axis_tlast = 4'($urandom);
      for (int k = 0; k < NUM_CH; k++) set_data(k, rand_data());
      settle();
      n_vec++;
      if ((axis_if.s_axis_tready & 4'b1011) !== 4'b0000)
        begin n_err++; $display("FAIL mask_tready c=%0d: got %b want only bit2", c, axis_if.s_axis_tready); end
      if (axis_if.m_axis_tvalid === 1'b1) begin
        n_vec++;
        if (axis_if.m_axis_tuser !== 2'd2)
          begin n_err++; $display("FAIL mask_tuser c=%0d: got %0d want 2", c, axis_if.m_axis_tuser); end
        ch2_beats++;
      end
      cycle();
    end
    n_vec++;
    if (ch2_beats == 0) begin n_err++; $display("FAIL mask_ch2_beats: got 0 want >0"); end
  endtask

  task automatic test_backpressure();
    int          b;
    bit          done1, saw0, stalled_prev;
    logic [DW-1:0] prev;
    logic [3:0]  pat;
    do_reset();
    ch_enable             = 4'hF;
    axis_if.s_axis_tvalid = 4'b0010;
    set_data(1, DW'(32'hB000));
    settle();
    cycle();
    axis_if.s_axis_tvalid = 4'b0011;
    axis_if.s_axis_tlast  = 4'b0001;
    set_data(0, DW'(32'hC0));
    pat          = 4'b1001;
    b            = 0;
    done1        = 0;
    saw0         = 0;
    stalled_prev = 0;
    prev         = '0;
    for (int t = 0; t < 40; t++) begin
      axis_if.m_axis_tready   = pat[t % 4];
      axis_if.s_axis_tlast[1] = (b == 3);
      set_data(1, DW'(32'hB000 + b));
      settle();
      if (!done1) begin
        n_vec++;
        if (axis_if.m_axis_tvalid !== 1'b1 || axis_if.m_axis_tuser !== 2'd1)
          begin n_err++; $display("FAIL bp_owner t=%0d: tvalid %b tuser %0d want 1/1", t, axis_if.m_axis_tvalid, axis_if.m_axis_tuser); end
        n_vec++;
        if (axis_if.s_axis_tready[0] !== 1'b0)
          begin n_err++; $display("FAIL bp_ch0_ready t=%0d: got %b want 0", t, axis_if.s_axis_tready[0]); end
        n_vec++;
        if (axis_if.m_axis_tdata !== DW'(32'hB000 + b))
          begin n_err++; $display("FAIL bp_tdata t=%0d: got %h want %h", t, axis_if.m_axis_tdata, 32'hB000 + b); end
        if (stalled_prev) begin
          n_vec++;
          if (axis_if.m_axis_tdata !== prev)
            begin n_err++; $display("FAIL bp_stable t=%0d: got %h want %h", t, axis_if.m_axis_tdata, prev); end
        end
        prev         = axis_if.m_axis_tdata;
        stalled_prev = (axis_if.m_axis_tready == 1'b0);
        if (axis_if.m_axis_tready) begin
          b++;
          if (b == 4) done1 = 1;
        end
      end else if (axis_if.m_axis_tvalid === 1'b1 && !saw0) begin
        n_vec++;
        if (axis_if.m_axis_tuser !== 2'd0)
          begin n_err++; $display("FAIL bp_next_grant: got %0d want 0", axis_if.m_axis_tuser); end
        saw0 = 1;
      end
      cycle();
      if (done1) axis_if.s_axis_tvalid[1] = 1'b0;
    end
    n_vec++;
    if (b != 4 || !saw0)
      begin n_err++; $display("FAIL bp_complete: ch1 beats %0d want 4, ch0 seen %0d want 1", b, saw0); end
  endtask

  task automatic test_mid_disable();
    int b;
    int ch2_beats;
    do_reset();
    ch_enable             = 4'hF;
    axis_if.s_axis_tvalid = 4'b1000;
    b                     = 0;
    for (int t = 0; t < 20 && b < 5; t++) begin
      axis_if.s_axis_tlast[3] = (b == 4);
      set_data(3, DW'(32'hD00 + b));
      if (b == 1) ch_enable[3] = 1'b0;
      settle();
      if (axis_if.m_axis_tvalid === 1'b1) begin
        n_vec++;
        if (axis_if.m_axis_tuser !== 2'd3 || axis_if.m_axis_tdata !== DW'(32'hD00 + b))
          begin n_err++; $display("FAIL dis_beat %0d: tuser %0d tdata %h want 3/%h", b, axis_if.m_axis_tuser, axis_if.m_axis_tdata, 32'hD00 + b); end
        b++;
      end
      cycle();
    end
    n_vec++;
    if (b != 5) begin n_err++; $display("FAIL dis_beats: got %0d want 5", b); end
    n_vec++;
    if (cnt_view[3] !== 32'd1) begin n_err++; $display("FAIL dis_cnt3: got %0d want 1", cnt_view[3]); end
    axis_if.s_axis_tvalid = 4'b1100;
    axis_if.s_axis_tlast  = 4'b0100;
    ch2_beats             = 0;
    for (int t = 0; t < 15; t++) begin
      axis_if.s_axis_tlast[3] = 1'($urandom);
      settle();
      if (axis_if.m_axis_tvalid === 1'b1) begin
        n_vec++;
        if (axis_if.m_axis_tuser !== 2'd2)
          begin n_err++; $display("FAIL dis_regrant t=%0d: got %0d want 2", t, axis_if.m_axis_tuser); end
        ch2_beats++;
      end
      cycle();
    end
    n_vec++;
    if (ch2_beats == 0) begin n_err++; $display("FAIL dis_ch2_beats: got 0 want >0"); end
  endtask

  task automatic test_clear_collision();
    bit fired;
    do_reset();
    ch_enable             = 4'hF;
    axis_if.s_axis_tvalid = 4'b0010;
    axis_if.s_axis_tlast  = 4'b0010;
    fired                 = 0;
    for (int t = 0; t < 40 && !fired; t++) begin
      cnt_clear = m_busy && (m_owner == 2'd1) && (m_cnt[1] == 32'd7);
      settle();
      if (cnt_clear) begin
        n_vec++;
        if (cnt_view[1] !== 32'd7 || axis_if.s_axis_tready[1] !== 1'b1)
          begin n_err++; $display("FAIL clr_pre: cnt1 %0d tready1 %b want 7/1", cnt_view[1], axis_if.s_axis_tready[1]); end
        fired = 1;
      end
      cycle();
      cnt_clear = 1'b0;
    end
    settle();
    n_vec++;
    if (!fired || cnt_view[1] !== 32'd0)
      begin n_err++; $display("FAIL clr_collision: fired %0d cnt1 %0d want 1/0", fired, cnt_view[1]); end
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    ch_enable             = 4'hF;
    axis_if.s_axis_tvalid = 4'b0100;
    cycle();
    cycle();
    ARESET                = 1'b1;
    axis_if.s_axis_tvalid = 4'hF;
    axis_if.s_axis_tlast  = 4'hF;
    settle();
    n_vec++;
    if (axis_if.m_axis_tvalid !== 1'b0 || axis_if.s_axis_tready !== '0)
      begin n_err++; $display("FAIL rstmid_during: tvalid %b tready %b want 0", axis_if.m_axis_tvalid, axis_if.s_axis_tready); end
    cycle();
    ARESET = 1'b0;
    settle();
    n_vec++;
    if (busy !== 1'b0 || axis_if.s_axis_tready !== '0 || axis_if.m_axis_tvalid !== 1'b0)
      begin n_err++; $display("FAIL rstmid_after: busy %b tready %b tvalid %b want 0", busy, axis_if.s_axis_tready, axis_if.m_axis_tvalid); end
    n_vec++;
    if (cnt_view[2] !== 32'd0) begin n_err++; $display("FAIL rstmid_cnt2: got %0d want 0", cnt_view[2]); end
    cycle();
    settle();
    n_vec++;
    if (axis_if.m_axis_tvalid !== 1'b1 || axis_if.m_axis_tuser !== 2'd0)
      begin n_err++; $display("FAIL rstmid_grant: tvalid %b tuser %0d want 1/0", axis_if.m_axis_tvalid, axis_if.m_axis_tuser); end
    cycle();
  endtask

  task automatic test_wrap();
    do_reset();
    ch_enable = 4'hF;
    force dut.cnt_q = {96'h0, 32'hFFFF_FFFF};
    #1;
    release dut.cnt_q;
    m_cnt[0] = 32'hFFFF_FFFF;
    settle();
    n_vec++;
    if (cnt_view[0] !== 32'hFFFF_FFFF)
      begin n_err++; $display("FAIL wrap_pre: got %h want ffffffff", cnt_view[0]); end
    axis_if.s_axis_tvalid = 4'b0001;
    axis_if.s_axis_tlast  = 4'b0001;
    cycle();
    cycle();
    axis_if.s_axis_tvalid = '0;
    settle();
    n_vec++;
    if (cnt_view[0] !== 32'd0) begin n_err++; $display("FAIL wrap_cnt0: got %h want 0", cnt_view[0]); end
  endtask

  task automatic test_random();
    do_reset();
    ch_enable = 4'($urandom);
    for (int c = 0; c < 600; c++) begin
      axis_if.s_axis_tvalid = 4'($urandom);
      axis_if.s_axis_tlast  = 4'($urandom);
      for (int k = 0; k < NUM_CH; k++) set_data(k, rand_data());
      axis_if.m_axis_tready = ($urandom_range(0, 9) < 7);
      cnt_clear             = ($urandom_range(0, 49) == 0);
      ARESET                = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 19) == 0) ch_enable = 4'($urandom);
      settle();
      n_vec++;
      if (axis_if.m_axis_tvalid !== e_valid)
        begin n_err++; $display("FAIL rnd_tvalid c=%0d: got %b want %b", c, axis_if.m_axis_tvalid, e_valid); end
      n_vec++;
      if (axis_if.s_axis_tready !== e_ready)
        begin n_err++; $display("FAIL rnd_tready c=%0d: got %b want %b", c, axis_if.s_axis_tready, e_ready); end
      n_vec++;
      if (busy !== m_busy)
        begin n_err++; $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, m_busy); end
      if (e_valid) begin
        n_vec++;
        if (axis_if.m_axis_tdata !== e_data || axis_if.m_axis_tuser !== e_user || axis_if.m_axis_tlast !== e_last)
          begin n_err++; $display("FAIL rnd_beat c=%0d: tuser %0d tlast %b tdata %h want %0d/%b/%h", c, axis_if.m_axis_tuser, axis_if.m_axis_tlast, axis_if.m_axis_tdata, e_user, e_last, e_data); end
      end
      for (int k = 0; k < NUM_CH; k++) begin
        n_vec++;
        if (cnt_view[k] !== m_cnt[k])
          begin n_err++; $display("FAIL rnd_cnt%0d c=%0d: got %0d want %0d", k, c, cnt_view[k], m_cnt[k]); end
      end
      cycle();
    end
    ARESET    = 1'b0;
    cnt_clear = 1'b0;
  endtask

  initial begin
    ARESET    = 1'b1;
    ch_enable = '0;
    idle_inputs();
    m_busy    = 0;
    m_owner   = '0;
    m_last    = CH_W'(NUM_CH - 1);
    for (int k = 0; k < NUM_CH; k++) m_cnt[k] = '0;
    @(negedge ACLK);
    test_reset();
    test_fairness();
    test_masking();
    test_backpressure();
    test_mid_disable();
    test_clear_collision();
    test_reset_midpacket();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_udp_channel_arbiter.md
ADC_UDP_CHANNEL_ARBITER -- requirements
Module: adc_udp_channel_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of ADC stream inputs (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 128, meaning the AXI-Stream tdata width in bits.
REQ-003 The block SHALL have parameter CH_W, default 2, meaning the channel ID width (clog2(NUM_CH)).

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port ACLK, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port ARESET, input, 1, a synchronous, active-high reset.
REQ-006 The block SHALL have port s_axis_tdata, input, NUM_CH*DATA_WIDTH, flattened per-channel data; channel k occupies slice k.
REQ-007 The block SHALL have ports s_axis_tvalid, s_axis_tlast, input, NUM_CH each, per-channel valid and end-of-packet.
REQ-008 The block SHALL have port s_axis_tready, output, NUM_CH, per-channel ready.
REQ-009 The block SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1), m_axis_tlast (output, 1) and m_axis_tready (input, 1), forming the merged stream to the UDP framer.
REQ-010 The block SHALL have port m_axis_tuser, output, CH_W, the source channel ID of the current beat.
REQ-011 The block SHALL have port ch_enable, input, NUM_CH, the per-channel enable mask, quasi-static and driven from the AXI4-Lite register bank.
REQ-012 The block SHALL have port cnt_clear, input, 1, a single-cycle pulse that clears the packet counters.
REQ-013 The block SHALL have port pkt_cnt, output, NUM_CH*32, per-channel completed-packet counters.
REQ-014 The block SHALL have port busy, output, 1, asserted while a packet transfer is in progress.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and XFER, and SHALL hold a grant register (CH_W bits) and a last_grant register (CH_W bits).
REQ-016 In IDLE, when at least one request is present (req = s_axis_tvalid & ch_enable, req != 0), the FSM SHALL load grant with the first set req bit, searching round-robin from last_grant+1 mod NUM_CH, and SHALL enter XFER on the next cycle.
REQ-017 Arbitration latency SHALL be one cycle: IDLE always lasts at least one cycle between packets.
REQ-018 In XFER, the merged-stream outputs SHALL be driven combinationally from the granted channel: m_axis_tdata, m_axis_tvalid and m_axis_tlast from the granted slice, and m_axis_tuser = grant.
REQ-019 In XFER, s_axis_tready[grant] SHALL equal m_axis_tready, and every other s_axis_tready bit SHALL be 0.
REQ-020 In IDLE, m_axis_tvalid SHALL be 0, m_axis_tlast SHALL be 0, and all s_axis_tready bits SHALL be 0.
REQ-021 Grants SHALL be packet-atomic: no channel switch occurs until a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast is accepted.
REQ-022 On that tlast handshake, the block SHALL set last_grant to grant, increment pkt_cnt[grant] by 1, and move the FSM to IDLE.
REQ-023 Each pkt_cnt SHALL be 32 bits and SHALL wrap from 0xFFFFFFFF to 0.
REQ-024 A cnt_clear pulse SHALL zero all counters on the next edge; if cnt_clear coincides with an increment, the clear SHALL win and the counter SHALL read 0.
REQ-025 Clearing ch_enable[grant] during XFER SHALL NOT abort the transfer: the packet completes, and the channel is excluded from later arbitration.
REQ-026 Setting a bit in ch_enable SHALL take effect at the next IDLE arbitration.
REQ-027 Backpressure (m_axis_tready=0) SHALL stall the granted channel only; the outputs mirror the stalled input unchanged, and the block adds no buffering.
REQ-028 busy SHALL be 1 exactly while the FSM is in XFER.

Reset
REQ-029 While ARESET=1 at a rising edge, the block SHALL enter IDLE with grant=0, last_grant=NUM_CH-1 (so ch0 has first priority), all pkt_cnt=0 and busy=0.
REQ-030 During and immediately after reset, m_axis_tvalid=0 and all s_axis_tready bits SHALL be 0.
REQ-031 A reset asserted mid-packet SHALL abandon the packet without incrementing any counter; the remainder of that packet is then treated by the arbiter as a new packet.

Verification
REQ-032 Fairness: all 4 channels valid, 2-beat packets, m_axis_tready=1, ch_enable=4'hF -> tuser sequence 0,0,1,1,2,2,3,3,0,..., with one idle cycle between packets; after 8 packets each pkt_cnt = 2.
REQ-033 Masking: ch_enable=4'b0100, all channels valid -> only channel 2 is granted; s_axis_tready[0,1,3] stay 0 throughout.
REQ-034 Backpressure: ch1 sends a 4-beat packet while m_axis_tready toggles 1,0,0,1,... and ch0 is valid -> m_axis_tdata holds stable during stalls, no ch0 beat is interleaved, and ch0 is granted only after ch1's tlast.
REQ-035 Mid-packet disable: ch_enable[3] cleared on beat 2 of a 5-beat ch3 packet -> all 5 beats pass, pkt_cnt[3] increments, and ch3 is not granted afterwards.
REQ-036 Clear collision: cnt_clear asserted in the same cycle as ch1's tlast handshake with pkt_cnt[1]=7 -> pkt_cnt[1]=0 on the next cycle.
REQ-037 Reset and wrap: ARESET pulsed mid-packet -> busy=0 and tready=0 on the next cycle and the next grant is ch0; separately, with pkt_cnt[0] forced to 0xFFFFFFFF, one ch0 packet -> pkt_cnt[0]=0.
